crypto_word_feeder: RTL and testbench
=====================================

CRYPTO_WORD_FEEDER -- requirements
Module: crypto_word_feeder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, which is the maximum number of cycles spent in WAIT before core_done is abandoned.
REQ-002 SHALL have clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have key_load, input, 1 bit, and key_in, input, 128 bits: key write strobe and key value.
REQ-005 SHALL have s_valid, input, 1 bit; s_data, input, 32 bits; s_ready, output, 1 bit: upstream plaintext word stream.
REQ-006 SHALL have core_start, output, 1 bit; core_key, output, 128 bits; core_data, output, 128 bits: drive signals to the crypto core.
REQ-007 SHALL have core_done, input, 1 bit, and core_result, input, 128 bits: completion flag and result from the crypto core.
REQ-008 SHALL have m_valid, output, 1 bit; m_data, output, 32 bits; m_ready, input, 1 bit: downstream ciphertext word stream.
REQ-009 SHALL have busy, output, 1 bit (state != FILL) and timeout_err, output, 1 bit (sticky).

Function
REQ-010 SHALL implement the states FILL, START, WAIT and DRAIN, with a 2-bit word counter wcnt.
REQ-011 FILL: s_ready=1; a word transfers on s_valid&&s_ready; word k (k=0..3) SHALL be written to core_data[127-32k -: 32]; wcnt increments per transfer.
REQ-012 FILL -> START on the cycle the 4th word (wcnt==3) transfers; wcnt returns to 0.
REQ-013 START: core_start=1 for exactly one cycle; the state then moves unconditionally to WAIT.
REQ-014 core_start SHALL be 0 in every state other than START.
REQ-015 WAIT: the block counts cycles; when core_done=1, core_result is captured into the output buffer and the state moves to DRAIN.
REQ-016 WAIT: if the counter reaches TIMEOUT with no core_done, the block SHALL set timeout_err, discard the block, and return to FILL.
REQ-017 The WAIT counter SHALL clear on entry to WAIT and SHALL be wide enough for TIMEOUT with no wrap-around.
REQ-018 DRAIN: m_valid=1 and m_data = buf[127-32k -: 32], most-significant word first; k advances on m_valid&&m_ready.
REQ-019 After the 4th output transfer the state SHALL move to FILL.
REQ-020 m_data SHALL hold stable while m_valid=1 and m_ready=0.
REQ-021 s_ready SHALL be 0 outside FILL; s_valid is ignored there, so no word is lost or consumed.
REQ-022 core_data and core_key SHALL remain stable from START through the end of WAIT.
REQ-023 key_load SHALL be accepted only in FILL with wcnt==0 and no transfer in that cycle; otherwise it is ignored.
REQ-024 If key_load and a word transfer occur in the same cycle at wcnt==0, the word transfer wins and the key is ignored.
REQ-025 A core_done seen in any state other than WAIT SHALL be ignored.
REQ-026 timeout_err SHALL clear only on reset.
REQ-027 Throughput is one block per 4 + 1 + core latency + 4 cycles minimum, with no overlap of FILL and DRAIN.

Reset
REQ-028 On reset=1 at a clock edge: state=FILL, wcnt=0, output index=0, WAIT counter=0.
REQ-029 On reset, the key register, core_data and the output buffer SHALL all be 0.
REQ-030 On reset, the outputs SHALL be: s_ready=1 (from the first cycle after reset deasserts), core_start=0, m_valid=0, busy=0, timeout_err=0.
REQ-031 A reset asserted mid-operation, in any state, SHALL abandon the block in progress; no partial output is emitted after reset.

Verification
REQ-032 Single block: key_load key=0x0; feed words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF; core returns core_data^key two cycles after start -> core_data=0x00112233_44556677_8899AABB_CCDDEEFF, exactly one core_start pulse, m_data emits those 4 words in order.
REQ-033 Backpressure: m_ready toggles 1,0,0,1,... during DRAIN -> each word is held while stalled, 4 transfers total, no duplicates.
REQ-034 Timeout: core_done tied to 0 -> timeout_err=1 exactly TIMEOUT cycles after WAIT entry, state=FILL, m_valid never asserted.
REQ-035 Key gating: key_load with 0xFF..FF asserted at wcnt=2 -> ignored, core_key unchanged; the same load at wcnt=0 with s_valid=0 -> core_key=0xFF..FF.
REQ-036 Reset mid-DRAIN after 2 output words -> m_valid=0 the next cycle; a fresh 4-word block then processes normally.
REQ-037 Stray core_done in FILL -> no state change, no output.

Source files
------------

// File: rtl/crypto_word_feeder.sv
// Packs four 32-bit words into a 128-bit block, runs it through an external crypto core,
// then streams the 128-bit result out as four words, most-significant word first.
module crypto_word_feeder #(
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         s_valid,
  input  logic [31:0]  s_data,
  output logic         s_ready,
  output logic         core_start,
  output logic [127:0] core_key,
  output logic [127:0] core_data,
  input  logic         core_done,
  input  logic [127:0] core_result,
  output logic         m_valid,
  output logic [31:0]  m_data,
  input  logic         m_ready,
  output logic         busy,
  output logic         timeout_err
);

  typedef enum logic [1:0] {FILL, START, WAIT, DRAIN} state_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [1:0]     wcnt_q, wcnt_d;
  logic [1:0]     ocnt_q, ocnt_d;
  logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   data_q, data_d;
  logic [127:0]   buf_q, buf_d;
  logic           err_q, err_d;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    ocnt_d     = ocnt_q;
    wait_cnt_d = wait_cnt_q;
    key_d      = key_q;
    data_d     = data_q;
    buf_d      = buf_q;
    err_d      = err_q;
    s_ready    = 1'b0;
    core_start = 1'b0;
    m_valid    = 1'b0;
    m_data     = buf_q[127 - 32*ocnt_q -: 32];

    case (state_q)
      FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          data_d[127 - 32*wcnt_q -: 32] = s_data;
          wcnt_d = wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) state_d = START;
        end else if (key_load && wcnt_q == 2'd0) begin
          // Key only changes between blocks, so a block never mixes two keys.
          key_d = key_in;
        end
      end
      START: begin
        core_start = 1'b1;
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          buf_d   = core_result;
          ocnt_d  = 2'd0;
          state_d = DRAIN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = FILL;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        m_valid = 1'b1;
        if (m_ready) begin
          ocnt_d = ocnt_q + 2'd1;
          if (ocnt_q == 2'd3) state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FILL;
      wcnt_q     <= '0;
      ocnt_q     <= '0;
      wait_cnt_q <= '0;
      key_q      <= '0;
      data_q     <= '0;
      buf_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      ocnt_q     <= ocnt_d;
      wait_cnt_q <= wait_cnt_d;
      key_q      <= key_d;
      data_q     <= data_d;
      buf_q      <= buf_d;
      err_q      <= err_d;
    end
  end

  assign busy        = (state_q != FILL);
  assign timeout_err = err_q;
  assign core_key    = key_q;
  assign core_data   = data_q;

endmodule

// File: tb/tb_crypto_word_feeder.sv
// Directed bench for crypto_word_feeder with a two-cycle XOR core model.
module tb_crypto_word_feeder;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_load;
  logic [127:0] key_in;
  logic         s_valid;
  logic [31:0]  s_data;
  logic         s_ready;
  logic         core_start;
  logic [127:0] core_key;
  logic [127:0] core_data;
  logic         core_done;
  logic [127:0] core_result;
  logic         m_valid;
  logic [31:0]  m_data;
  logic         m_ready;
  logic         busy;
  logic         timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]  in_w [4];
  logic [31:0]  got_w [4];
  int           got_n;
  int           starts;

  logic         core_en = 1'b1;
  logic         stray_done = 1'b0;
  logic         d1 = 1'b0;
  logic         d2 = 1'b0;
  logic [127:0] res = '0;

  crypto_word_feeder #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .key_load(key_load), .key_in(key_in),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .core_start(core_start), .core_key(core_key), .core_data(core_data),
    .core_done(core_done), .core_result(core_result),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Core model: done two cycles after start, result = data ^ key.
  always @(posedge clk) begin
    d1 <= core_start && core_en;
    d2 <= d1;
    if (core_start) res <= core_data ^ core_key;
  end
  assign core_done   = d2 | stray_done;
  assign core_result = res;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic feed_words(input int first);
    for (int k = first; k < 4; k++) begin
      s_valid = 1'b1;
      s_data  = in_w[k];
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic collect;
    m_ready = 1'b1;
    got_n   = 0;
    starts  = 0;
    for (int c = 0; c < 64 && got_n < 4; c++) begin
      if (core_start) starts++;
      if (m_valid) begin
        got_w[got_n] = m_data;
        got_n++;
      end
      tick();
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; key_load = 1'b0; key_in = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_s_ready: got %b expected 1", s_ready); end
    n_tests++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL rst_core_start: got %b expected 0", core_start); end
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b expected 0", m_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout_err: got %b expected 0", timeout_err); end
    n_tests++; if (core_key !== 128'h0) begin n_fail++; $display("FAIL rst_core_key: got %h expected 0", core_key); end
    n_tests++; if (core_data !== 128'h0) begin n_fail++; $display("FAIL rst_core_data: got %h expected 0", core_data); end
  endtask

  task automatic test_single_block;
    key_in = '0; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    in_w = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    feed_words(0);
    n_tests++; if (core_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b expected 1", core_start); end
    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL single_s_ready: got %b expected 0", s_ready); end
    n_tests++;
    if (core_data !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin
      n_fail++; $display("FAIL single_core_data: got %h expected 00112233445566778899aabbccddeeff", core_data);
    end
    collect();
    n_tests++; if (got_n !== 4) begin n_fail++; $display("FAIL single_count: got %0d expected 4", got_n); end
    n_tests++; if (starts !== 1) begin n_fail++; $display("FAIL single_starts: got %0d expected 1", starts); end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (got_w[k] !== in_w[k]) begin n_fail++; $display("FAIL single_word%0d: got %h expected %h", k, got_w[k], in_w[k]); end
    end
    n_tests++; if (busy !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_done: got busy=%b m_valid=%b expected 0 0", busy, m_valid);
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] k;
    logic [31:0]  exp_w [4];
    int pat [4] = '{1, 0, 0, 1};
    int got = 0;
    int vcyc = 0;
    int p = 0;
    int w = 0;
    k = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    key_in = k; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    in_w = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3};
    exp_w = '{32'hA0A1A2A3 ^ 32'h01234567, 32'hB0B1B2B3 ^ 32'h89ABCDEF,
              32'hC0C1C2C3 ^ 32'hFEDCBA98, 32'hD0D1D2D3 ^ 32'h76543210};
    feed_words(0);
    m_ready = 1'b0;
    while (!m_valid && w < 16) begin tick(); w++; end
    n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_wait: got m_valid=%b expected 1", m_valid); end
    for (int c = 0; c < 32 && got < 4; c++) begin
      n_tests++;
      if (m_valid !== 1'b1 || m_data !== exp_w[got]) begin
        n_fail++; $display("FAIL bp_word%0d: got valid=%b data=%h expected 1 %h", got, m_valid, m_data, exp_w[got]);
      end
      m_ready = (pat[p % 4] != 0);
      p++;
      vcyc++;
      if (m_ready) got++;
      tick();
    end
    m_ready = 1'b0;
    n_tests++; if (got !== 4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", got); end
    n_tests++; if (vcyc !== 8) begin n_fail++; $display("FAIL bp_cycles: got %0d expected 8", vcyc); end
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_end_valid: got %b expected 0", m_valid); end
  endtask

  task automatic test_timeout;
    logic seen = 1'b0;
    core_en = 1'b0;
    in_w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    feed_words(0);
    for (int i = 1; i <= TO + 1; i++) begin
      tick();
      if (m_valid) seen = 1'b1;
      if (i == TO) begin
        n_tests++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin
          n_fail++; $display("FAIL to_early: got err=%b busy=%b expected 0 1", timeout_err, busy);
        end
      end
      if (i == TO + 1) begin
        n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b expected 1", timeout_err); end
        n_tests++; if (busy !== 1'b0 || s_ready !== 1'b1) begin
          n_fail++; $display("FAIL to_fill: got busy=%b s_ready=%b expected 0 1", busy, s_ready);
        end
      end
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL to_no_output: got m_valid seen=%b expected 0", seen); end
    core_en = 1'b1;
  endtask

  task automatic test_key_gating;
    logic [127:0] k_old;
    logic [127:0] ones;
    k_old = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    ones  = '1;
    in_w = '{32'h0000FFFF, 32'h12345678, 32'h9ABCDEF0, 32'hFFFF0000};
    for (int k = 0; k < 2; k++) begin s_valid = 1'b1; s_data = in_w[k]; tick(); end
    s_valid = 1'b0;
    key_in = ones; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    n_tests++; if (core_key !== k_old) begin n_fail++; $display("FAIL key_wcnt2: got %h expected %h", core_key, k_old); end
    feed_words(2);
    n_tests++; if (core_key !== k_old) begin n_fail++; $display("FAIL key_start: got %h expected %h", core_key, k_old); end
    collect();
    n_tests++;
    if ({got_w[0], got_w[1], got_w[2], got_w[3]} !== ({in_w[0], in_w[1], in_w[2], in_w[3]} ^ k_old)) begin
      n_fail++; $display("FAIL key_old_block: got %h%h%h%h expected %h", got_w[0], got_w[1], got_w[2], got_w[3],
                         {in_w[0], in_w[1], in_w[2], in_w[3]} ^ k_old);
    end
    n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", timeout_err); end
    key_in = ones; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    n_tests++; if (core_key !== ones) begin n_fail++; $display("FAIL key_wcnt0: got %h expected all ones", core_key); end
    in_w = '{32'hCAFEBABE, 32'hDEADBEEF, 32'h0BADF00D, 32'h8BADF00D};
    key_in = 128'h55555555_55555555_55555555_55555555; key_load = 1'b1;
    s_valid = 1'b1; s_data = in_w[0];
    tick();
    key_load = 1'b0; s_valid = 1'b0;
    n_tests++; if (core_key !== ones) begin n_fail++; $display("FAIL key_vs_word: got %h expected all ones", core_key); end
    n_tests++; if (core_data[127:96] !== in_w[0]) begin n_fail++; $display("FAIL word_vs_key: got %h expected %h", core_data[127:96], in_w[0]); end
    feed_words(1);
    collect();
    n_tests++;
    if ({got_w[0], got_w[1], got_w[2], got_w[3]} !== ({in_w[0], in_w[1], in_w[2], in_w[3]} ^ ones)) begin
      n_fail++; $display("FAIL key_new_block: got %h%h%h%h expected %h", got_w[0], got_w[1], got_w[2], got_w[3],
                         {in_w[0], in_w[1], in_w[2], in_w[3]} ^ ones);
    end
  endtask

  task automatic test_reset_mid_drain;
    int w = 0;
    in_w = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
    feed_words(0);
    m_ready = 1'b1;
    while (!m_valid && w < 16) begin tick(); w++; end
    tick();
    tick();
    n_tests++; if (m_valid !== 1'b1 || m_data !== ~32'h03030303) begin
      n_fail++; $display("FAIL mid_word2: got valid=%b data=%h expected 1 %h", m_valid, m_data, ~32'h03030303);
    end
    reset = 1'b1; m_ready = 1'b0;
    tick();
    n_tests++; if (m_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst: got m_valid=%b busy=%b expected 0 0", m_valid, busy);
    end
    n_tests++; if (timeout_err !== 1'b0 || core_key !== 128'h0) begin
      n_fail++; $display("FAIL mid_rst_regs: got err=%b key=%h expected 0 0", timeout_err, core_key);
    end
    reset = 1'b0;
    in_w = '{32'h76543210, 32'hFEDCBA98, 32'h13579BDF, 32'h2468ACE0};
    feed_words(0);
    collect();
    n_tests++;
    if (got_n !== 4 || {got_w[0], got_w[1], got_w[2], got_w[3]} !== {in_w[0], in_w[1], in_w[2], in_w[3]}) begin
      n_fail++; $display("FAIL mid_fresh: got n=%0d %h%h%h%h expected 4 %h%h%h%h", got_n,
                         got_w[0], got_w[1], got_w[2], got_w[3], in_w[0], in_w[1], in_w[2], in_w[3]);
    end
  endtask

  task automatic test_stray_done;
    stray_done = 1'b1;
    tick();
    tick();
    stray_done = 1'b0;
    n_tests++; if (busy !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
      n_fail++; $display("FAIL stray: got busy=%b m_valid=%b s_ready=%b expected 0 0 1", busy, m_valid, s_ready);
    end
    tick();
    n_tests++; if (m_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stray_after: got m_valid=%b busy=%b expected 0 0", m_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_backpressure();
    test_timeout();
    test_key_gating();
    test_reset_mid_drain();
    test_stray_done();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
